// File: rtl/lsd_norm_pkg.sv
// Shared sizing helpers for the leading-sign normalisation scheduler and its arbiter.
package lsd_norm_pkg;

  // Requester id width; a single requester still gets a 1-bit id.
  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int sh_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/LeadSignDet.sv
// Leading-sign detector: one-hot marks the highest bit below the MSB that differs from the sign.
module LeadSignDet #(
  parameter int WIDTH = 16,
  parameter int SPEED = 0
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-2:0] onehot_o,
  output logic             allsign_o
);

  logic [WIDTH-2:0] diff;
  logic [WIDTH-2:0] seen;

  assign diff = data_i[WIDTH-2:0] ^ {(WIDTH-1){data_i[WIDTH-1]}};

  // seen[i] is the OR of diff from bit i up to the top; SPEED picks the prefix network.
  generate
    if (SPEED == 0) begin : g_ripple
      always_comb begin
        logic [WIDTH-2:0] acc;
        acc = '0;
        acc[WIDTH-2] = diff[WIDTH-2];
        for (int i = WIDTH - 3; i >= 0; i--) begin
          acc[i] = acc[i+1] | diff[i];
        end
        seen = acc;
      end
    end else if (SPEED == 1) begin : g_radix2
      always_comb begin
        logic [WIDTH-2:0] acc;
        acc = diff;
        for (int s = 1; s < WIDTH - 1; s = s * 2) begin
          acc = acc | (acc >> s);
        end
        seen = acc;
      end
    end else begin : g_radix4
      always_comb begin
        logic [WIDTH-2:0] acc;
        acc = diff;
        for (int s = 1; s < WIDTH - 1; s = s * 4) begin
          acc = acc | (acc >> s) | (acc >> (2 * s)) | (acc >> (3 * s));
        end
        seen = acc;
      end
    end
  endgenerate

  assign onehot_o  = diff & ~(seen >> 1);
  assign allsign_o = ~seen[0];

endmodule

// File: rtl/lsd_norm_sched_arb.sv
// Round-robin arbiter: combinational grant from the pointer upward, pointer moves past each winner.
module lsd_rr_arbiter
  import lsd_norm_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREQ-1:0]        valid_i,
  input  logic                   adv_i,
  output logic [NREQ-1:0]        grant_o,
  output logic [id_w(NREQ)-1:0]  id_o
);

  localparam int IDW = id_w(NREQ);

  logic [IDW-1:0] ptr;
  logic           found;

  always_comb begin
    int idx;
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && valid_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = IDW'(idx);
      end
    end
  end

  // Pointer only moves on an actual handshake, to the slot just after the winner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (adv_i && found) begin
      ptr <= (id_o == IDW'(NREQ - 1)) ? '0 : id_o + 1'b1;
    end
  end

endmodule

// File: rtl/lsd_norm_sched.sv
// Shares one leading-sign detector and normalising shifter among NREQ requesters
// through a two-stage capture/normalise pipeline.
module lsd_norm_sched
  import lsd_norm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int SPEED = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*WIDTH-1:0]   req_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [id_w(NREQ)-1:0]   out_id_o,
  output logic [sh_w(WIDTH)-1:0]  out_shamt_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic                    out_allsign_o,
  output logic                    busy_o
);

  localparam int IDW = id_w(NREQ);
  localparam int SHW = sh_w(WIDTH);

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] data;
    logic             allsign;
  } lsd_res_t;

  logic             s1_v;
  logic [IDW-1:0]   s1_id;
  logic [WIDTH-1:0] s1_data;
  logic             s2_v;
  lsd_res_t         s2_res;

  logic             s2_adv;
  logic             s1_adv;
  logic             arb_adv;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             handshake;
  logic [WIDTH-1:0] req_sel;

  logic [WIDTH-2:0] lsd_onehot;
  logic             lsd_allsign;
  logic [SHW-1:0]   lsd_pos;
  lsd_res_t         res_next;

  assign s2_adv = !s2_v || out_ready_i;
  assign s1_adv = !s1_v || s2_adv;

  // Reset is folded in so ready reads zero for the whole time reset is held.
  assign arb_adv = s1_adv && !flush_i && rst_ni;

  lsd_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (req_valid_i),
    .adv_i   (arb_adv),
    .grant_o (grant),
    .id_o    (grant_id)
  );

  assign req_ready_o = grant & {NREQ{arb_adv}};
  assign handshake   = |req_ready_o;
  assign req_sel     = req_data_i[int'(grant_id)*WIDTH +: WIDTH];

  LeadSignDet #(
    .WIDTH (WIDTH),
    .SPEED (SPEED)
  ) u_lsd (
    .data_i    (s1_data),
    .onehot_o  (lsd_onehot),
    .allsign_o (lsd_allsign)
  );

  always_comb begin
    lsd_pos = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (lsd_onehot[i]) begin
        lsd_pos = lsd_pos | SHW'(i);
      end
    end
  end

  // Shift brings the first non-sign bit to WIDTH-2; an all-sign word takes the full WIDTH-1.
  always_comb begin
    res_next.id      = s1_id;
    res_next.allsign = lsd_allsign;
    res_next.shamt   = lsd_allsign ? SHW'(WIDTH - 1) : SHW'(WIDTH - 2) - lsd_pos;
    res_next.data    = s1_data << res_next.shamt;
  end

  // S2 is only rewritten when it advances and S1 has data, so stalled outputs hold still.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v    <= 1'b0;
      s1_id   <= '0;
      s1_data <= '0;
      s2_v    <= 1'b0;
      s2_res  <= '0;
    end else if (flush_i) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_res <= res_next;
        end
      end
      if (s1_adv) begin
        s1_v <= handshake;
        if (handshake) begin
          s1_id   <= grant_id;
          s1_data <= req_sel;
        end
      end
    end
  end

  assign out_valid_o   = s2_v;
  assign out_id_o      = s2_res.id;
  assign out_shamt_o   = s2_res.shamt;
  assign out_data_o    = s2_res.data;
  assign out_allsign_o = s2_res.allsign;
  assign busy_o        = s1_v || s2_v;

endmodule

// File: tb/tb_lsd_norm_sched.sv
// Self-checking bench for lsd_norm_sched at WIDTH=8, NREQ=4: directed scenarios plus a
// randomized run against a behavioural pipeline/round-robin model.
module tb_lsd_norm_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int SHW   = 3;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  flush_i;
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ*WIDTH-1:0] req_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [IDW-1:0]        out_id_o;
  logic [SHW-1:0]        out_shamt_o;
  logic [WIDTH-1:0]      out_data_o;
  logic                  out_allsign_o;
  logic                  busy_o;

  int checks   = 0;
  int failures = 0;

  lsd_norm_sched #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .SPEED (0)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_data_i    (req_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_id_o      (out_id_o),
    .out_shamt_o   (out_shamt_o),
    .out_data_o    (out_data_o),
    .out_allsign_o (out_allsign_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference normalisation: count the run of leading sign bits, shift it down to one.
  function automatic logic [SHW+WIDTH:0] norm(input logic [WIDTH-1:0] a);
    int               n;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] d;
    n = 1;
    while (n < WIDTH && a[WIDTH-1-n] == a[WIDTH-1]) n++;
    sh = (n == WIDTH) ? SHW'(WIDTH - 1) : SHW'(n - 1);
    d  = a << sh;
    return {sh, d, (n == WIDTH)};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni      = 1'b1;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    #2 rst_ni   = 1'b0;
    req_valid_i = '1;
    #1;
    checks++;
    if (req_ready_o !== '0) begin
      failures++;
      $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready_o);
    end
    checks++;
    if ({out_valid_o, busy_o, out_id_o, out_shamt_o, out_data_o, out_allsign_o} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got v=%b b=%b id=%0d sh=%0d d=%h as=%b expected all 0",
               out_valid_o, busy_o, out_id_o, out_shamt_o, out_data_o, out_allsign_o);
    end
    req_valid_i = '0;
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick();
    checks++;
    if ({out_valid_o, busy_o} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_idle: got valid=%b busy=%b expected 0 0", out_valid_o, busy_o);
    end
  endtask

  // All requesters always valid: grants rotate 0,1,2,3 and results stream with no bubbles.
  task automatic test_rr_fairness();
    logic [IDW-1:0]   qid[$];
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] a[NREQ];
    logic [IDW-1:0]   eid;
    logic [WIDTH-1:0] ea;
    logic [NREQ-1:0]  erdy;
    for (int r = 0; r < NREQ; r++) begin
      a[r] = WIDTH'($urandom);
      req_data_i[r*WIDTH +: WIDTH] = a[r];
    end
    out_ready_i = 1'b1;
    req_valid_i = '1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      checks++;
      if (out_valid_o !== 1'(cyc >= 2)) begin
        failures++;
        $display("[TB] FAIL rr_valid cyc=%0d: got %b expected %b", cyc, out_valid_o, cyc >= 2);
      end
      if (cyc >= 2) begin
        eid = qid.pop_front();
        ea  = qa.pop_front();
        checks++;
        if ({out_id_o, out_shamt_o, out_data_o, out_allsign_o} !== {eid, norm(ea)}) begin
          failures++;
          $display("[TB] FAIL rr_result cyc=%0d: got id=%0d sh=%0d d=%h as=%b expected id=%0d operand=%h",
                   cyc, out_id_o, out_shamt_o, out_data_o, out_allsign_o, eid, ea);
        end
      end
      erdy = NREQ'(1) << (cyc % NREQ);
      checks++;
      if (req_ready_o !== erdy) begin
        failures++;
        $display("[TB] FAIL rr_grant cyc=%0d: got %b expected %b", cyc, req_ready_o, erdy);
      end
      qid.push_back(IDW'(cyc % NREQ));
      qa.push_back(a[cyc % NREQ]);
      tick();
      a[cyc % NREQ] = WIDTH'($urandom);
      req_data_i[(cyc % NREQ)*WIDTH +: WIDTH] = a[cyc % NREQ];
    end
    req_valid_i = '0;
    for (int k = 0; k < 2; k++) begin
      eid = qid.pop_front();
      ea  = qa.pop_front();
      checks++;
      if ({out_valid_o, out_id_o, out_shamt_o, out_data_o, out_allsign_o} !== {1'b1, eid, norm(ea)}) begin
        failures++;
        $display("[TB] FAIL rr_drain k=%0d: got v=%b id=%0d d=%h expected id=%0d operand=%h",
                 k, out_valid_o, out_id_o, out_data_o, eid, ea);
      end
      tick();
    end
  endtask

  // Three ops against a stalled sink: two get in, ready drops, order survives the release.
  task automatic test_backpressure();
    logic [NREQ-1:0]  vtab[9] = '{4'b1110, 4'b1100, 4'b1000, 4'b1000, 4'b1000,
                                  4'b1000, 4'b0000, 4'b0000, 4'b0000};
    logic [NREQ-1:0]  rtab[9] = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000,
                                  4'b1000, 4'b0000, 4'b0000, 4'b0000};
    int               otab[9] = '{-1, -1, 1, 1, 1, 1, 2, 3, -1};
    logic [WIDTH-1:0] a[NREQ];
    int               accepted;
    accepted = 0;
    for (int r = 0; r < NREQ; r++) begin
      a[r] = WIDTH'($urandom);
      req_data_i[r*WIDTH +: WIDTH] = a[r];
    end
    for (int cyc = 0; cyc < 9; cyc++) begin
      req_valid_i = vtab[cyc];
      out_ready_i = (cyc >= 5);
      #1;
      if (cyc < 5) accepted += $countones(req_ready_o & req_valid_i);
      checks++;
      if (req_ready_o !== rtab[cyc]) begin
        failures++;
        $display("[TB] FAIL bp_ready cyc=%0d: got %b expected %b", cyc, req_ready_o, rtab[cyc]);
      end
      checks++;
      if (otab[cyc] < 0) begin
        if (out_valid_o !== 1'b0) begin
          failures++;
          $display("[TB] FAIL bp_out cyc=%0d: got valid=%b expected 0", cyc, out_valid_o);
        end
      end else if ({out_valid_o, out_id_o, out_shamt_o, out_data_o, out_allsign_o} !==
                   {1'b1, IDW'(otab[cyc]), norm(a[otab[cyc]])}) begin
        failures++;
        $display("[TB] FAIL bp_out cyc=%0d: got v=%b id=%0d d=%h expected id=%0d operand=%h",
                 cyc, out_valid_o, out_id_o, out_data_o, otab[cyc], a[otab[cyc]]);
      end
      if (cyc == 4) begin
        checks++;
        if (accepted !== 2) begin
          failures++;
          $display("[TB] FAIL bp_accepted: got %0d expected 2", accepted);
        end
      end
      tick();
    end
  endtask

  // Flush with both stages full: pipeline empties, nothing accepted, pointer kept at 2.
  task automatic test_flush();
    logic [NREQ-1:0]  vtab[9] = '{4'b0011, 4'b0010, 4'b1101, 4'b1101, 4'b1001,
                                  4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic [NREQ-1:0]  rtab[9] = '{4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b1000,
                                  4'b0001, 4'b0000, 4'b0000, 4'b0000};
    int               otab[9] = '{-1, -1, 0, -1, -1, 2, 3, 0, -1};
    logic [WIDTH-1:0] a[NREQ];
    for (int r = 0; r < NREQ; r++) begin
      a[r] = WIDTH'($urandom);
      req_data_i[r*WIDTH +: WIDTH] = a[r];
    end
    for (int cyc = 0; cyc < 9; cyc++) begin
      req_valid_i = vtab[cyc];
      flush_i     = (cyc == 2);
      out_ready_i = (cyc >= 2);
      #1;
      checks++;
      if (req_ready_o !== rtab[cyc]) begin
        failures++;
        $display("[TB] FAIL flush_ready cyc=%0d: got %b expected %b", cyc, req_ready_o, rtab[cyc]);
      end
      checks++;
      if (otab[cyc] < 0) begin
        if (out_valid_o !== 1'b0) begin
          failures++;
          $display("[TB] FAIL flush_out cyc=%0d: got valid=%b expected 0", cyc, out_valid_o);
        end
      end else if ({out_valid_o, out_id_o, out_shamt_o, out_data_o, out_allsign_o} !==
                   {1'b1, IDW'(otab[cyc]), norm(a[otab[cyc]])}) begin
        failures++;
        $display("[TB] FAIL flush_out cyc=%0d: got v=%b id=%0d d=%h expected id=%0d operand=%h",
                 cyc, out_valid_o, out_id_o, out_data_o, otab[cyc], a[otab[cyc]]);
      end
      if (cyc == 3) begin
        checks++;
        if (busy_o !== 1'b0) begin
          failures++;
          $display("[TB] FAIL flush_busy: got %b expected 0", busy_o);
        end
      end
      tick();
    end
    flush_i = 1'b0;
  endtask

  // Isolated ops: two-cycle latency and the documented normalisation corner cases.
  task automatic test_single();
    int               tr[6] = '{0, 2, 1, 3, 0, 1};
    logic [WIDTH-1:0] ta[6] = '{8'h05, 8'hFA, 8'h40, 8'hBF, 8'h00, 8'hFF};
    logic [SHW+WIDTH:0] te[6] = '{{3'd4, 8'h50, 1'b0}, {3'd4, 8'hA0, 1'b0}, {3'd0, 8'h40, 1'b0},
                                  {3'd0, 8'hBF, 1'b0}, {3'd7, 8'h00, 1'b1}, {3'd7, 8'h80, 1'b1}};
    int                 r;
    logic [WIDTH-1:0]   a;
    logic [SHW+WIDTH:0] e;
    out_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) begin
        r = tr[i];
        a = ta[i];
        e = te[i];
      end else begin
        r = int'($urandom_range(0, NREQ - 1));
        a = WIDTH'($urandom);
        e = norm(a);
      end
      req_data_i[r*WIDTH +: WIDTH] = a;
      req_valid_i = NREQ'(1) << r;
      #1;
      checks++;
      if (req_ready_o !== (NREQ'(1) << r)) begin
        failures++;
        $display("[TB] FAIL single_ready op=%0d: got %b expected %b", i, req_ready_o, NREQ'(1) << r);
      end
      tick();
      req_valid_i = '0;
      checks++;
      if ({out_valid_o, busy_o} !== 2'b01) begin
        failures++;
        $display("[TB] FAIL single_s1 op=%0d: got valid=%b busy=%b expected 0 1", i, out_valid_o, busy_o);
      end
      tick();
      checks++;
      if ({out_valid_o, out_id_o, out_shamt_o, out_data_o, out_allsign_o} !== {1'b1, IDW'(r), e}) begin
        failures++;
        $display("[TB] FAIL single_result A=%h: got v=%b id=%0d sh=%0d d=%h as=%b expected id=%0d sh=%0d d=%h as=%b",
                 a, out_valid_o, out_id_o, out_shamt_o, out_data_o, out_allsign_o,
                 r, e[SHW+WIDTH:WIDTH+1], e[WIDTH:1], e[0]);
      end
      tick();
      checks++;
      if (out_valid_o !== 1'b0) begin
        failures++;
        $display("[TB] FAIL single_drain op=%0d: got valid=%b expected 0", i, out_valid_o);
      end
    end
  endtask

  // Reset in mid-stream: outputs clear at once, nothing replays, pointer restarts at 0.
  task automatic test_async_reset();
    for (int r = 0; r < NREQ; r++) req_data_i[r*WIDTH +: WIDTH] = WIDTH'($urandom);
    out_ready_i = 1'b0;
    req_valid_i = 4'b0110;
    tick();
    req_valid_i = 4'b0100;
    tick();
    req_valid_i = '0;
    #2 rst_ni = 1'b0;
    req_valid_i = 4'b1101;
    #1;
    checks++;
    if ({req_ready_o, out_valid_o, busy_o, out_id_o, out_shamt_o, out_data_o, out_allsign_o} !== '0) begin
      failures++;
      $display("[TB] FAIL areset_outputs: got rdy=%b v=%b b=%b id=%0d sh=%0d d=%h as=%b expected all 0",
               req_ready_o, out_valid_o, busy_o, out_id_o, out_shamt_o, out_data_o, out_allsign_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL areset_ptr: got %b expected 0001", req_ready_o);
    end
    req_valid_i = '0;
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({out_valid_o, busy_o} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL areset_replay k=%0d: got valid=%b busy=%b expected 0 0", k, out_valid_o, busy_o);
      end
    end
  endtask

  // Random requesters, sink readiness and flushes against a two-slot pipeline model.
  task automatic test_random();
    logic             pend[NREQ];
    logic [WIDTH-1:0] pdata[NREQ];
    int               m_ptr;
    logic             m_s1v, m_s2v;
    int               m_s1id, m_s2id;
    logic [WIDTH-1:0] m_s1a, m_s2a;
    logic             s2a, s1a, hs;
    int               g;
    logic [NREQ-1:0]  erdy;
    for (int r = 0; r < NREQ; r++) begin
      pend[r]  = 1'b0;
      pdata[r] = '0;
    end
    m_ptr = 0; m_s1v = 1'b0; m_s2v = 1'b0;
    m_s1id = 0; m_s2id = 0; m_s1a = '0; m_s2a = '0;
    req_valid_i = '0;
    flush_i     = 1'b0;
    rst_ni      = 1'b0;
    #3 rst_ni   = 1'b1;
    tick();
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!pend[r] && $urandom_range(0, 99) < 45) begin
          pend[r]  = 1'b1;
          pdata[r] = WIDTH'($urandom);
        end
        req_valid_i[r] = pend[r];
        req_data_i[r*WIDTH +: WIDTH] = pdata[r];
      end
      out_ready_i = ($urandom_range(0, 99) < 65);
      flush_i     = ($urandom_range(0, 99) < 4);
      #1;
      s2a = !m_s2v || out_ready_i;
      s1a = !m_s1v || s2a;
      g   = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && pend[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
      hs   = (g >= 0) && s1a && !flush_i;
      erdy = hs ? (NREQ'(1) << g) : '0;
      checks++;
      if (req_ready_o !== erdy) begin
        failures++;
        $display("[TB] FAIL rand_ready cyc=%0d: got %b expected %b", cyc, req_ready_o, erdy);
      end
      checks++;
      if ({out_valid_o, busy_o} !== {m_s2v, m_s1v || m_s2v}) begin
        failures++;
        $display("[TB] FAIL rand_valid cyc=%0d: got valid=%b busy=%b expected %b %b",
                 cyc, out_valid_o, busy_o, m_s2v, m_s1v || m_s2v);
      end
      if (m_s2v) begin
        checks++;
        if ({out_id_o, out_shamt_o, out_data_o, out_allsign_o} !== {IDW'(m_s2id), norm(m_s2a)}) begin
          failures++;
          $display("[TB] FAIL rand_result cyc=%0d: got id=%0d sh=%0d d=%h as=%b expected id=%0d operand=%h",
                   cyc, out_id_o, out_shamt_o, out_data_o, out_allsign_o, m_s2id, m_s2a);
        end
      end
      if (flush_i) begin
        m_s1v = 1'b0;
        m_s2v = 1'b0;
      end else begin
        if (s2a) begin
          m_s2v  = m_s1v;
          m_s2id = m_s1id;
          m_s2a  = m_s1a;
        end
        if (s1a) begin
          m_s1v = hs;
          if (hs) begin
            m_s1id = g;
            m_s1a  = pdata[g];
          end
        end
      end
      if (hs) begin
        pend[g] = 1'b0;
        m_ptr   = (g + 1) % NREQ;
      end
      tick();
    end
    req_valid_i = '0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_backpressure();
    test_flush();
    test_single();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
